// File: rtl/abs_min_max_pkg.sv
// Shared definitions for the abs/min/max pipeline.
// Holds the mode encodings and helpers that return the extreme two's-complement
// values for a given operand width.
package abs_min_max_pkg;

    localparam logic [1:0] MODE_ABS     = 2'b00;
    localparam logic [1:0] MODE_MIN     = 2'b01;
    localparam logic [1:0] MODE_MAX     = 2'b10;
    localparam logic [1:0] MODE_ABSDIFF = 2'b11;

    // Most-negative value -2^(width-1), as a bit pattern in the low width bits.
    function automatic logic [31:0] most_neg(input int unsigned width);
        logic [31:0] one;
        one = 32'd1;
        return one << (width - 1);
    endfunction

    // Most-positive value 2^(width-1)-1.
    function automatic logic [31:0] most_pos(input int unsigned width);
        return most_neg(width) - 32'd1;
    endfunction

endpackage

// File: rtl/abs_min_max_if.sv
// Operand/result handshake bundle for abs_min_max_pipe.
// in_*  : operand bundle (valid/ready, A, B, mode) from the sequencer.
// out_* : result bundle (valid/ready, data, lt/eq/sat flags) to the register file.
// master: the side that supplies operands and consumes results.
// slave : the datapath itself.
interface abs_min_max_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_lt;
    logic             out_eq;
    logic             out_sat;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_lt, out_eq, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_lt, out_eq, out_sat
    );

endinterface

// File: rtl/signed_cmp_sub.sv
// Widened signed subtractor/comparator.
// a_i, b_i : signed WIDTH-bit operands.
// diff_o   : sext(a) - sext(b) in WIDTH+1 bits; never overflows.
// lt_o     : a < b (signed), taken from the widened sign bit.
// eq_o     : a == b.
module signed_cmp_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH:0]   diff_o,
    output logic             lt_o,
    output logic             eq_o
);

    assign diff_o = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};
    assign lt_o   = diff_o[WIDTH];
    assign eq_o   = (diff_o == '0);

endmodule

// File: rtl/abs_min_max_pipe.sv
// Two-stage valid/ready abs/min/max/absdiff datapath.
// clk   : rising-edge clock.
// rst_n : synchronous active-low reset; flushes both stages.
// bus   : abs_min_max_if slave port carrying the operand bundle
//         (in_valid/in_ready/in_a/in_b/in_mode) and the result bundle
//         (out_valid/out_ready/out_data/out_lt/out_eq/out_sat).
// Stage 1 registers the operands and the widened difference; stage 2 selects
// the result and flags. Both stages stall together under backpressure.
module abs_min_max_pipe
    import abs_min_max_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    abs_min_max_if.slave bus
);

    localparam logic [WIDTH-1:0] MostNeg = WIDTH'(most_neg(WIDTH));
    localparam logic [WIDTH-1:0] MostPos = WIDTH'(most_pos(WIDTH));

    logic             adv2;
    logic             accept;

    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH:0]   cmp_diff;
    logic             cmp_lt;
    logic             cmp_eq;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH:0]   diff_q, diff_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_lt_q, out_lt_d;
    logic             out_eq_q, out_eq_d;
    logic             out_sat_q, out_sat_d;

    // Stage 2 can take a new value whenever its slot is empty or being drained.
    assign adv2         = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || adv2;
    assign accept       = bus.in_valid && bus.in_ready;

    // ABS is computed as 0 - B so the same subtractor yields -B.
    assign cmp_a = (bus.in_mode == MODE_ABS) ? '0 : bus.in_a;

    signed_cmp_sub #(
        .WIDTH(WIDTH)
    ) u_cmp (
        .a_i   (cmp_a),
        .b_i   (bus.in_b),
        .diff_o(cmp_diff),
        .lt_o  (cmp_lt),
        .eq_o  (cmp_eq)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        mode_d     = mode_q;
        diff_d     = diff_q;
        lt_d       = lt_q;
        eq_d       = eq_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = bus.in_a;
            b_d        = bus.in_b;
            mode_d     = bus.in_mode;
            diff_d     = cmp_diff;
            lt_d       = cmp_lt;
            eq_d       = cmp_eq;
        end else if (adv2) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lt_d    = out_lt_q;
        out_eq_d    = out_eq_q;
        out_sat_d   = out_sat_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_lt_d  = (mode_q != MODE_ABS) && lt_q;
                out_eq_d  = (mode_q != MODE_ABS) && eq_q;
                out_sat_d = (mode_q == MODE_ABS) && (b_q == MostNeg);
                case (mode_q)
                    MODE_ABS: begin
                        if (b_q == MostNeg) begin
                            out_data_d = MostPos;
                        end else begin
                            out_data_d = b_q[WIDTH-1] ? diff_q[WIDTH-1:0] : b_q;
                        end
                    end
                    MODE_MIN: out_data_d = lt_q ? a_q : b_q;
                    MODE_MAX: out_data_d = lt_q ? b_q : a_q;
                    // |A-B| fits in WIDTH unsigned bits, so truncation is exact.
                    MODE_ABSDIFF: out_data_d = lt_q ? WIDTH'(-diff_q) : diff_q[WIDTH-1:0];
                    default: out_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_ABS;
            diff_q      <= '0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lt_q    <= 1'b0;
            out_eq_q    <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            diff_q      <= diff_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lt_q    <= out_lt_d;
            out_eq_q    <= out_eq_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_lt    = out_lt_q;
    assign bus.out_eq    = out_eq_q;
    assign bus.out_sat   = out_sat_q;

endmodule
